conv1d_sequencer: RTL and testbench

Sequences conv1d_core over a stored input vector for each of NUM_FILTERS weight sets. It holds a weight/bias bank and a sample buffer, both loaded through simple write ports. On each go it loads one filter's weights, flushes the core window, streams the samples, collects the core results and moves to the next filter. It sits between the board control logic and conv1d_core, replacing hand-sequenced start/data_valid stimulus.

---
 rtl/conv1d_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_conv1d_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: drives conv1d_core over a stored sample vector once per filter.
// Define CONV_SEQ_RELU_EN to clip negative results to 0 and count clipped results.
module conv1d_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int NUM_FILTERS = 2,
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [$clog2(NUM_FILTERS*4)-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  smp_we,
    input  logic [DATA_WIDTH-1:0] smp_data,
    input  logic [$clog2(MAX_LEN):0] seq_len,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len,
    output logic                  err_timeout,
    output logic                  core_rst_n,
    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_data_in,
    output logic                  core_data_valid,
    output logic [DATA_WIDTH-1:0] core_weight0,
    output logic [DATA_WIDTH-1:0] core_weight1,
    output logic [DATA_WIDTH-1:0] core_weight2,
    output logic [DATA_WIDTH-1:0] core_bias,
    input  logic [DATA_WIDTH-1:0] core_conv_out,
    input  logic                  core_out_valid,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [((NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1)-1:0] res_filter,
    output logic [$clog2(MAX_LEN)-1:0] res_index
`ifdef CONV_SEQ_RELU_EN
    ,
    output logic [7:0]            relu_clip_cnt
`endif
);

    localparam int CAW = $clog2(NUM_FILTERS * 4);
    localparam int FW  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int IW  = $clog2(MAX_LEN);
    localparam int LW  = IW + 1;
    localparam int TW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] bank    [NUM_FILTERS][4];
    logic [DATA_WIDTH-1:0] smp_buf [MAX_LEN];
    logic [DATA_WIDTH-1:0] go_w    [4];
    logic [IW-1:0]         wr_ptr;
    logic [LW-1:0]         len;
    logic [LW-1:0]         k;
    logic [LW-1:0]         cnt;
    logic [LW-1:0]         exp_n;
    logic [FW-1:0]         filt;
    logic [TW-1:0]         tcnt;
    logic                  core_rst_q;
    logic [FW-1:0]         cfg_fi;
    logic [1:0]            cfg_slot;
    logic                  cfg_ok;
    logic                  len_bad;
    logic                  take_res;
    logic                  drain_hit;
    logic                  drain_to;

    assign core_rst_n = core_rst_q & ~rst;
    assign cfg_fi     = FW'(cfg_addr >> 2);
    assign cfg_slot   = cfg_addr[1:0];
    assign cfg_ok     = int'(cfg_addr >> 2) < NUM_FILTERS;
    assign len_bad    = (seq_len < LW'(KERNEL_SIZE)) ||
                        (seq_len > LW'(MAX_LEN));
    assign take_res   = (state == S_STREAM || state == S_DRAIN) &&
                        core_out_valid && (cnt < exp_n);
    assign drain_hit  = (cnt == exp_n);
    assign drain_to   = !core_out_valid && (tcnt == TW'(TIMEOUT - 1));

    // A config write landing on the go cycle must reach the core weights.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            go_w[i] = bank[0][i];
            if (cfg_we && cfg_ok && cfg_fi == '0 && cfg_slot == 2'(i))
                go_w[i] = cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && smp_we)
            smp_buf[wr_ptr] <= smp_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_len         <= 1'b0;
            err_timeout     <= 1'b0;
            core_rst_q      <= 1'b1;
            core_start      <= 1'b0;
            core_data_in    <= '0;
            core_data_valid <= 1'b0;
            core_weight0    <= '0;
            core_weight1    <= '0;
            core_weight2    <= '0;
            core_bias       <= '0;
            res_valid       <= 1'b0;
            res_data        <= '0;
            res_filter      <= '0;
            res_index       <= '0;
            wr_ptr          <= '0;
            len             <= '0;
            k               <= '0;
            cnt             <= '0;
            exp_n           <= '0;
            filt            <= '0;
            tcnt            <= '0;
`ifdef CONV_SEQ_RELU_EN
            relu_clip_cnt   <= '0;
`endif
            for (int f = 0; f < NUM_FILTERS; f++)
                for (int s = 0; s < 4; s++)
                    bank[f][s] <= '0;
        end else begin
            done      <= 1'b0;
            res_valid <= 1'b0;
            if (state == S_IDLE && smp_we)
                wr_ptr <= wr_ptr + 1'b1;
            if (take_res) begin
                res_valid  <= 1'b1;
                res_filter <= filt;
                res_index  <= cnt[IW-1:0];
                cnt        <= cnt + 1'b1;
`ifdef CONV_SEQ_RELU_EN
                if (core_conv_out[DATA_WIDTH-1]) begin
                    res_data <= '0;
                    if (relu_clip_cnt != 8'hFF)
                        relu_clip_cnt <= relu_clip_cnt + 1'b1;
                end else begin
                    res_data <= core_conv_out;
                end
`else
                res_data <= core_conv_out;
`endif
            end
            unique case (state)
                S_IDLE: begin
                    if (cfg_we && cfg_ok)
                        bank[cfg_fi][cfg_slot] <= cfg_data;
                    if (go && len_bad) begin
                        err_len <= 1'b1;
                        done    <= 1'b1;
                    end else if (go) begin
                        len          <= seq_len;
                        exp_n        <= seq_len - LW'(KERNEL_SIZE - 1);
                        filt         <= '0;
                        cnt          <= '0;
                        err_len      <= 1'b0;
                        err_timeout  <= 1'b0;
                        busy         <= 1'b1;
                        core_rst_q   <= 1'b0;
                        core_weight0 <= go_w[0];
                        core_weight1 <= go_w[1];
                        core_weight2 <= go_w[2];
                        core_bias    <= go_w[3];
`ifdef CONV_SEQ_RELU_EN
                        relu_clip_cnt <= '0;
`endif
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    core_rst_q      <= 1'b1;
                    core_data_in    <= smp_buf[0];
                    core_data_valid <= 1'b1;
                    core_start      <= 1'b1;
                    k               <= LW'(1);
                    state           <= S_STREAM;
                end
                S_STREAM: begin
                    if (k == len) begin
                        core_data_valid <= 1'b0;
                        core_start      <= 1'b0;
                        tcnt            <= '0;
                        state           <= S_DRAIN;
                    end else begin
                        core_data_in <= smp_buf[k[IW-1:0]];
                        k            <= k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_hit || drain_to) begin
                        if (!drain_hit)
                            err_timeout <= 1'b1;
                        if (filt < FW'(NUM_FILTERS - 1)) begin
                            filt         <= filt + 1'b1;
                            cnt          <= '0;
                            core_rst_q   <= 1'b0;
                            core_weight0 <= bank[filt + 1'b1][0];
                            core_weight1 <= bank[filt + 1'b1][1];
                            core_weight2 <= bank[filt + 1'b1][2];
                            core_bias    <= bank[filt + 1'b1][3];
                            state        <= S_LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end else if (core_out_valid) begin
                        tcnt <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_FIN: begin
                    busy   <= 1'b0;
                    wr_ptr <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_sequencer.sv
// tb_conv1d_sequencer: scoreboard bench with a behavioural conv1d_core model.
module tb_conv1d_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        smp_we = 1'b0;
    logic [15:0] smp_data = '0;
    logic [4:0]  seq_len = '0;
    logic        go = 1'b0;
    logic        busy, done, err_len, err_timeout;
    logic        core_rst_n, core_start, core_data_valid;
    logic [15:0] core_data_in;
    logic [15:0] core_weight0, core_weight1, core_weight2, core_bias;
    logic [15:0] core_conv_out = '0;
    logic        core_out_valid = 1'b0;
    logic        res_valid;
    logic [15:0] res_data;
    logic [0:0]  res_filter;
    logic [3:0]  res_index;
`ifdef CONV_SEQ_RELU_EN
    logic [7:0]  relu_clip_cnt;
`endif

    always #5 clk = ~clk;

    conv1d_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .smp_we(smp_we), .smp_data(smp_data),
        .seq_len(seq_len), .go(go),
        .busy(busy), .done(done),
        .err_len(err_len), .err_timeout(err_timeout),
        .core_rst_n(core_rst_n), .core_start(core_start),
        .core_data_in(core_data_in), .core_data_valid(core_data_valid),
        .core_weight0(core_weight0), .core_weight1(core_weight1),
        .core_weight2(core_weight2), .core_bias(core_bias),
        .core_conv_out(core_conv_out), .core_out_valid(core_out_valid),
        .res_valid(res_valid), .res_data(res_data),
        .res_filter(res_filter), .res_index(res_index)
`ifdef CONV_SEQ_RELU_EN
        , .relu_clip_cnt(relu_clip_cnt)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: 3-tap window, Q8.8 MAC, result one cycle after the third sample.
    logic        m_silent = 1'b0;
    logic        m_inject = 1'b0;
    logic        m_prev = 1'b0;
    logic [15:0] mx1 = '0, mx2 = '0;
    int          mn = 0;

    function automatic logic [15:0] mac(input logic [15:0] a, b, c);
        logic signed [31:0] s;
        s = $signed(a) * $signed(core_weight0)
          + $signed(b) * $signed(core_weight1)
          + $signed(c) * $signed(core_weight2);
        s = s >>> 8;
        return s[15:0] + core_bias;
    endfunction

    always @(posedge clk) begin
        if (!core_rst_n) begin
            mn             <= 0;
            core_out_valid <= 1'b0;
            m_prev         <= 1'b0;
        end else begin
            core_out_valid <= 1'b0;
            m_prev         <= 1'b0;
            if (core_data_valid) begin
                mx1 <= mx2;
                mx2 <= core_data_in;
                mn  <= mn + 1;
                if (mn >= 2 && !m_silent) begin
                    core_out_valid <= 1'b1;
                    m_prev         <= 1'b1;
                    core_conv_out  <= mac(mx1, mx2, core_data_in);
                end
            end else if (m_prev && m_inject) begin
                core_out_valid <= 1'b1;
                core_conv_out  <= 16'h7777;
            end
        end
    end

    typedef struct {
        int          f;
        int          idx;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    int   n_rst_low = 0;
    int   n_done = 0;
    int   first_v = -1;
    int   go_cyc = 0;
    bit   busy_seen = 0;

    always @(negedge clk) begin
        if (res_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got f=%0d i=%0d d=%h, required none",
                         res_filter, res_index, res_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (int'(res_filter) != e.f || int'(res_index) != e.idx || res_data !== e.d) begin
                    n_fail++;
                    $display("FAIL result: got f=%0d i=%0d d=%h, required f=%0d i=%0d d=%h",
                             res_filter, res_index, res_data, e.f, e.idx, e.d);
                end
            end
        end
        if (!rst && !core_rst_n) n_rst_low++;
        if (core_data_valid) begin
            n_valid++;
            if (first_v < 0) first_v = cyc;
        end
        if (done) n_done++;
        if (busy) busy_seen = 1;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    task automatic cfg(input int f, input int s, input logic [15:0] v);
        cfg_we = 1'b1;
        cfg_addr = 3'(f * 4 + s);
        cfg_data = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic smp(input logic [15:0] v);
        smp_we = 1'b1;
        smp_data = v;
        @(negedge clk);
        smp_we = 1'b0;
    endtask

    task automatic load_bank();
        cfg(0, 0, 16'h0100); cfg(0, 1, 16'h0080);
        cfg(0, 2, 16'h0040); cfg(0, 3, 16'h0020);
        cfg(1, 0, 16'h0080); cfg(1, 1, 16'h0080);
        cfg(1, 2, 16'h0080); cfg(1, 3, 16'h0000);
    endtask

    task automatic push(input int f, input int i, input logic [15:0] d);
        exp_t e;
        e.f = f; e.idx = i; e.d = d;
        q.push_back(e);
    endtask

    task automatic start_go(input int len);
        n_valid = 0; n_rst_low = 0; n_done = 0;
        first_v = -1; busy_seen = 0;
        go_cyc = cyc;
        seq_len = 5'(len);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        for (int i = 0; i < lim && n_done == 0; i++) @(negedge clk);
        if (n_done == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_done_timeout: got no done, required done within %0d cycles", nm, lim);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", core_data_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_err_len", err_len, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_core_rst_n", core_rst_n, 1);

        // Basic two-filter run, one result per filter
        load_bank();
        smp(16'h0200); smp(16'h0180); smp(16'h0100);
        push(0, 0, 16'h0320); push(1, 0, 16'h0240);
        start_go(3);
        wait_done("t1", 400);
        chk("t1_first_valid_lat", first_v - go_cyc, 2);
        chk("t1_core_rst_pulses", n_rst_low, 2);
        chk("t1_valid_cycles", n_valid, 6);
        chk("t1_done_pulses", n_done, 1);
        chk("t1_busy_after", busy, 0);
        chk("t1_pending", q.size(), 0);
        chk("t1_err_timeout", err_timeout, 0);

        // Longer pass; an extra core output after the last must be dropped
        smp(16'h0100); smp(16'h0200); smp(16'h0300); smp(16'h0400); smp(16'h0500);
        m_inject = 1'b1;
        push(0, 0, 16'h02E0); push(0, 1, 16'h04A0); push(0, 2, 16'h0660);
        push(1, 0, 16'h0300); push(1, 1, 16'h0480); push(1, 2, 16'h0600);
        start_go(5);
        wait_done("t2", 400);
        m_inject = 1'b0;
        chk("t2_valid_cycles", n_valid, 10);
        chk("t2_done_pulses", n_done, 1);
        chk("t2_pending", q.size(), 0);

        // Rejected lengths
        start_go(2);
        wait_done("t3a", 20);
        chk("t3a_err_len", err_len, 1);
        chk("t3a_valid_cycles", n_valid, 0);
        chk("t3a_busy_seen", busy_seen, 0);
        chk("t3a_done_pulses", n_done, 1);
        start_go(17);
        wait_done("t3b", 20);
        chk("t3b_err_len", err_len, 1);
        chk("t3b_valid_cycles", n_valid, 0);
        chk("t3b_busy_seen", busy_seen, 0);

        // Silent core: each filter times out
        m_silent = 1'b1;
        start_go(3);
        wait_done("t4", 400);
        m_silent = 1'b0;
        chk("t4_err_timeout", err_timeout, 1);
        chk("t4_err_len_cleared", err_len, 0);
        chk("t4_core_rst_pulses", n_rst_low, 2);
        chk("t4_done_pulses", n_done, 1);
        chk("t4_pending", q.size(), 0);

        // go/cfg/smp pulsed mid-stream are ignored
        smp(16'h0200); smp(16'h0180); smp(16'h0100);
        push(0, 0, 16'h0320); push(1, 0, 16'h0240);
        start_go(3);
        @(negedge clk);
        go = 1'b1; seq_len = 5'd5;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'h7FFF;
        smp_we = 1'b1; smp_data = 16'h1234;
        @(negedge clk);
        go = 1'b0; cfg_we = 1'b0; smp_we = 1'b0;
        wait_done("t5", 400);
        chk("t5_valid_cycles", n_valid, 6);
        chk("t5_done_pulses", n_done, 1);
        chk("t5_pending", q.size(), 0);
        chk("t5_err_timeout_cleared", err_timeout, 0);
        push(0, 0, 16'h0320); push(0, 1, 16'h0320);
        push(1, 0, 16'h0240); push(1, 1, 16'h0340);
        start_go(4);
        wait_done("t5b", 400);
        chk("t5b_pending", q.size(), 0);

        // Reset in DRAIN aborts the run without done
        m_silent = 1'b1;
        start_go(3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_core_rst_n_in_rst", core_rst_n, 0);
        rst = 1'b0;
        m_silent = 1'b0;
        @(negedge clk);
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_weight_cleared", core_weight0, 0);
        repeat (80) @(negedge clk);
        chk("t6_no_done", n_done, 0);
        load_bank();
        smp(16'h0200); smp(16'h0180); smp(16'h0100);
        push(0, 0, 16'h0320); push(1, 0, 16'h0240);
        start_go(3);
        wait_done("t6b", 400);
        chk("t6b_done_pulses", n_done, 1);
        chk("t6b_pending", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
